noc_output_scheduler: RTL and testbench

- Per-output-port scheduler for the NoC router. One instance sits on each of the 4 router output ports.
- Shares the port between the input packet holders with round-robin arbitration. A grant is held for the whole packet.
- Captures the granted 32-bit packet, pulses that holder's release, and serialises the packet as 4 bytes to the node using the free/put handshake.
- Replaces fixed-priority output selection so no single input can starve the others.

---
 rtl/noc_output_scheduler.sv | 137 +++++++++++++
 tb/tb_noc_output_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_scheduler.sv
// rtl/noc_output_scheduler.sv - round-robin output-port scheduler with 4-byte packet serialiser
module noc_output_scheduler #(
    parameter int NUM_IN     = 4,
    parameter int SELF_INDEX = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_IN-1:0]      req,
    input  logic [NUM_IN-1:0][31:0] pkt_in,
    output logic [NUM_IN-1:0]      took,
    input  logic                   free_outbound,
    output logic                   put_outbound,
    output logic [7:0]             payload_outbound,
    output logic                   busy,
    output logic [2:0]             grant_idx,
    output logic [CNT_W-1:0]       sent_count
);

    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FREE = 2'd1,
        SEND      = 2'd2
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_rr_ptr;
    logic [NUM_IN-1:0]   r_took;
    logic                r_put;
    logic [7:0]          r_payload;
    logic                r_busy;
    logic [2:0]          r_grant_idx;
    logic [CNT_W-1:0]    r_sent_count;
    logic [1:0]          r_byte_cnt;
    logic [31:0]         r_pkt;

    logic [NUM_IN-1:0]   w_eff;
    logic [2*NUM_IN-1:0] w_rot;
    logic                w_found;
    int                  w_gint;
    int                  w_nint;
    logic [IW-1:0]       w_gsel;
    logic [IW-1:0]       w_next_ptr;
    logic [NUM_IN-1:0]   w_onehot;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_eff
        assign w_eff[gi] = req[gi] && (gi != SELF_INDEX);
    end

    // Rotating the doubled request vector by rr_ptr turns the circular scan into a plain low-to-high search.
    always_comb begin
        w_rot   = {w_eff, w_eff} >> r_rr_ptr;
        w_found = 1'b0;
        w_gint  = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_gint  = int'(r_rr_ptr) + k;
            end
        end
        if (w_gint >= NUM_IN) begin
            w_gint = w_gint - NUM_IN;
        end
        w_nint     = (w_gint + 1 >= NUM_IN) ? 0 : w_gint + 1;
        w_gsel     = IW'(w_gint);
        w_next_ptr = IW'(w_nint);
        w_onehot   = NUM_IN'(1) << w_gsel;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_took       <= '0;
            r_put        <= 1'b0;
            r_payload    <= '0;
            r_busy       <= 1'b0;
            r_grant_idx  <= '0;
            r_sent_count <= '0;
            r_byte_cnt   <= '0;
            r_pkt        <= '0;
        end else begin
            r_took <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_pkt       <= pkt_in[w_gsel];
                        r_grant_idx <= 3'(w_gsel);
                        r_rr_ptr    <= w_next_ptr;
                        r_took      <= w_onehot;
                        r_busy      <= 1'b1;
                        r_state     <= WAIT_FREE;
                    end
                end
                WAIT_FREE: begin
                    if (free_outbound) begin
                        r_state    <= SEND;
                        r_byte_cnt <= '0;
                        r_put      <= 1'b1;
                        r_payload  <= r_pkt[31:24];
                    end
                end
                SEND: begin
                    // Once free is seen the node takes all four bytes, so free is not re-checked here.
                    if (r_byte_cnt == 2'd3) begin
                        r_put        <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                        r_sent_count <= r_sent_count + CNT_W'(1);
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0:    r_payload <= r_pkt[23:16];
                            2'd1:    r_payload <= r_pkt[15:8];
                            default: r_payload <= r_pkt[7:0];
                        endcase
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_put   <= 1'b0;
                end
            endcase
        end
    end

    assign took             = r_took;
    assign put_outbound     = r_put;
    assign payload_outbound = r_payload;
    assign busy             = r_busy;
    assign grant_idx        = r_grant_idx;
    assign sent_count       = r_sent_count;

endmodule

// File: tb/tb_noc_output_scheduler.sv
// tb/tb_noc_output_scheduler.sv - directed self-checking bench for noc_output_scheduler
module tb_noc_output_scheduler;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        req = '0;
    logic [3:0][31:0]  pkt_in = '0;
    logic [3:0]        took;
    logic              free_outbound = 1'b0;
    logic              put_outbound;
    logic [7:0]        payload_outbound;
    logic              busy;
    logic [2:0]        grant_idx;
    logic [1:0]        sent_count;

    int n_checks = 0;
    int n_fail   = 0;

    noc_output_scheduler #(.NUM_IN(4), .SELF_INDEX(0), .CNT_W(2)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req              (req),
        .pkt_in           (pkt_in),
        .took             (took),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .busy             (busy),
        .grant_idx        (grant_idx),
        .sent_count       (sent_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset_n       = 1'b0;
        req           = '0;
        free_outbound = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Observes one grant and the following burst; returns zeros if either never shows up.
    task automatic run_packet(output logic [3:0] t, output logic [31:0] b, output int plen);
        int c;
        t = '0; b = '0; plen = 0; c = 0;
        do begin
            step();
            c++;
        end while (took == 4'b0 && c < 20);
        t = took;
        c = 0;
        while (put_outbound !== 1'b1 && c < 50) begin
            step();
            c++;
        end
        while (put_outbound === 1'b1 && plen < 6) begin
            if (plen < 4) b = {b[23:0], payload_outbound};
            plen++;
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        n_checks++;
        if (took !== 4'b0 || put_outbound !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: took=%b put=%b busy=%b want 0000 0 0", took, put_outbound, busy);
        end
        n_checks++;
        if (payload_outbound !== 8'h00 || grant_idx !== 3'd0 || sent_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: payload=%h grant=%0d sent=%0d want 00 0 0", payload_outbound, grant_idx, sent_count);
        end
    endtask

    task automatic test_basic();
        logic [3:0]  t;
        logic [31:0] b;
        int          plen;
        logic [7:0]  exp_bytes [4] = '{8'h35, 8'hAA, 8'hBB, 8'hCC};
        apply_reset();
        free_outbound = 1'b1;
        pkt_in[2] = 32'h35AABBCC;
        req = 4'b0100;
        step();
        n_checks++;
        if (took !== 4'b0100 || grant_idx !== 3'd2 || busy !== 1'b1 || put_outbound !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_grant: took=%b grant=%0d busy=%b put=%b want 0100 2 1 0", took, grant_idx, busy, put_outbound);
        end
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (put_outbound !== 1'b1 || payload_outbound !== exp_bytes[i] || took !== 4'b0) begin
                n_fail++;
                $display("FAIL basic_byte%0d: put=%b payload=%h took=%b want 1 %h 0000", i, put_outbound, payload_outbound, took, exp_bytes[i]);
            end
        end
        step();
        n_checks++;
        if (put_outbound !== 1'b0 || sent_count !== 2'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: put=%b sent=%0d busy=%b want 0 1 0", put_outbound, sent_count, busy);
        end
        // rr_ptr is now 3, so holder 3 wins over holder 1.
        pkt_in[1] = 32'h11111111;
        pkt_in[3] = 32'h4F010203;
        req = 4'b1010;
        run_packet(t, b, plen);
        req = 4'b0000;
        n_checks++;
        if (t !== 4'b1000 || b !== 32'h4F010203 || plen !== 4) begin
            n_fail++;
            $display("FAIL basic_rrptr: took=%b bytes=%h len=%0d want 1000 4f010203 4", t, b, plen);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  t;
        logic [31:0] b;
        int          plen;
        int          exp_g;
        apply_reset();
        free_outbound = 1'b1;
        for (int i = 0; i < 4; i++) pkt_in[i] = {4'(i), 4'hA, 24'(i * 3 + 1)};
        req = 4'b1110;
        for (int k = 0; k < 9; k++) begin
            if (k == 6) req = 4'b1111;
            exp_g = (k % 3) + 1;
            run_packet(t, b, plen);
            n_checks++;
            if (t !== 4'(1 << exp_g) || b !== pkt_in[exp_g] || plen !== 4) begin
                n_fail++;
                $display("FAIL rr_grant%0d: took=%b bytes=%h len=%0d want %b %h 4", k, t, b, plen, 4'(1 << exp_g), pkt_in[exp_g]);
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_wait_free();
        logic [7:0] exp_bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        apply_reset();
        free_outbound = 1'b0;
        pkt_in[1] = 32'h12345678;
        req = 4'b0010;
        step();
        n_checks++;
        if (took !== 4'b0010) begin
            n_fail++;
            $display("FAIL wait_took: took=%b want 0010", took);
        end
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (put_outbound !== 1'b0 || busy !== 1'b1 || took !== 4'b0) begin
                n_fail++;
                $display("FAIL wait_hold%0d: put=%b busy=%b took=%b want 0 1 0000", i, put_outbound, busy, took);
            end
        end
        free_outbound = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            free_outbound = 1'b0;
            n_checks++;
            if (put_outbound !== 1'b1 || payload_outbound !== exp_bytes[i]) begin
                n_fail++;
                $display("FAIL free_drop_byte%0d: put=%b payload=%h want 1 %h", i, put_outbound, payload_outbound, exp_bytes[i]);
            end
        end
        step();
        n_checks++;
        if (put_outbound !== 1'b0 || sent_count !== 2'd1) begin
            n_fail++;
            $display("FAIL wait_done: put=%b sent=%0d want 0 1", put_outbound, sent_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        free_outbound = 1'b1;
        pkt_in[1] = 32'hDEADBEEF;
        pkt_in[3] = 32'h33333333;
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        step();
        step();
        n_checks++;
        if (put_outbound !== 1'b1 || payload_outbound !== 8'hBE) begin
            n_fail++;
            $display("FAIL mid_byte2: put=%b payload=%h want 1 be", put_outbound, payload_outbound);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (put_outbound !== 1'b0 || busy !== 1'b0 || sent_count !== 2'd0 || took !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_async: put=%b busy=%b sent=%0d took=%b want 0 0 0 0000", put_outbound, busy, sent_count, took);
        end
        req = 4'b1010;
        step();
        reset_n = 1'b1;
        step();
        // rr_ptr was 2 before reset; holder 1 winning shows it returned to 0.
        n_checks++;
        if (took !== 4'b0010 || grant_idx !== 3'd1 || sent_count !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_regrant: took=%b grant=%0d sent=%0d want 0010 1 0", took, grant_idx, sent_count);
        end
        req = 4'b0000;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_wrap();
        logic [3:0]  t;
        logic [31:0] b;
        int          plen;
        logic [1:0]  exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        free_outbound = 1'b1;
        pkt_in[2] = 32'h35AABBCC;
        req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            run_packet(t, b, plen);
            n_checks++;
            if (sent_count !== exp_cnt[k] || t !== 4'b0100 || plen !== 4) begin
                n_fail++;
                $display("FAIL wrap%0d: sent=%0d took=%b len=%0d want %0d 0100 4", k, sent_count, t, plen, exp_cnt[k]);
            end
        end
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_wait_free();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
